instr_encoder_loader: RTL and testbench
=======================================

// Module: instr_encoder_loader
// PURPOSE
//  Inverse of the main decoder: packs instruction fields (class, rd, rs1, rs2, funct3, funct7b5, imm)
//  into 32-bit RV32I words for R, LW, SW, BEQ, ADDI and JAL.
//  Writes each word sequentially into instruction memory through a registered valid/ready port.
//  Used by the bench/boot path to load programs before the 5-stage core leaves reset.
// PARAMETERS
//  BASE_ADDR  32'h0000_0000  byte address of the first word written after start
//  MAX_WORDS  256            capacity; number of words written before overflow is flagged
// PORTS
//  clk          in   1   rising-edge clock
//  rst_n        in   1   asynchronous, active-low reset
//  start        in   1   1-cycle pulse; IDLE->LOAD; reloads address to BASE_ADDR; clears count and flags
//  in_valid     in   1   field bundle valid
//  in_ready     out  1   bundle accepted when in_valid && in_ready
//  in_class     in   3   0=R 1=LW 2=SW 3=BEQ 4=ADDI 5=JAL; 6,7 illegal
//  in_rd        in   5   destination register
//  in_rs1       in   5   source register 1
//  in_rs2       in   5   source register 2
//  in_funct3    in   3   funct3 for R/ADDI (LW/SW forced 010, BEQ forced 000)
//  in_funct7b5  in   1   R only: bit 30 (sub/sra)
//  in_imm       in   21  signed immediate, byte offset for BEQ/JAL
//  in_last      in   1   marks final bundle of the program
//  imem_we      out  1   write valid to instruction memory
//  imem_ready   in   1   memory accepts write when imem_we && imem_ready
//  imem_addr    out  32  byte address of the current write
//  imem_wdata   out  32  encoded instruction
//  busy         out  1   state != IDLE
//  done         out  1   1-cycle pulse on DONE->IDLE transition
//  word_count   out  9   words written since start (saturates at MAX_WORDS)
//  err_illegal  out  1   sticky: illegal class accepted and dropped
//  err_imm      out  1   sticky: immediate out of range or misaligned; bundle dropped
//  err_ovf      out  1   sticky: bundle offered with word_count==MAX_WORDS
// BEHAVIOUR
//  Reset: state=IDLE. All outputs 0. imem_addr=BASE_ADDR; word_count=0.
//  FSM IDLE -start-> LOAD.
//   LOAD -(last bundle's write handshake) or overflow-> DONE.
//   DONE -> IDLE next cycle; done=1 for that one cycle.
//  start is ignored outside IDLE.
//  in_ready = (state==LOAD) && (!imem_we || imem_ready) && !last_seen && (word_count+imem_we < MAX_WORDS).
//  Latency: bundle accepted at edge N -> imem_we/imem_wdata/imem_addr valid from edge N+1.
//   They hold stable until imem_ready. Back-to-back throughput is one word/cycle.
//  On write handshake: imem_addr += 4 (32-bit wrap) and word_count += 1.
//   If no new bundle is loaded in the same cycle, imem_we drops.
//  Encoding, with the standard opcode in [6:0]:
//   R    {0,f7b5,5'b0,rs2,rs1,f3,rd,0110011}
//   LW   {imm[11:0],rs1,010,rd,0000011}
//   SW   {imm[11:5],rs2,rs1,010,imm[4:0],0100011}
//   BEQ  {imm[12],imm[10:5],rs2,rs1,000,imm[4:1],imm[11],1100011}
//   ADDI {imm[11:0],rs1,f3,rd,0010011}
//   JAL  {imm[20],imm[10:1],imm[11],imm[19:12],rd,1101111}
//  Range checks:
//   LW/SW/ADDI need imm in [-2048,2047].
//   BEQ needs [-4096,4094] and imm[0]==0.
//   JAL needs imm[0]==0; the full 21-bit range is legal.
//   Unused fields are ignored.
//  Rejected bundles (illegal class, bad imm) are consumed (in_ready=1), set the sticky flag, and are never written.
//   If a rejected bundle carries in_last: state -> DONE once any pending write completes.
//  Overflow: in_valid while word_count==MAX_WORDS and no write pending -> err_ovf=1, state -> DONE.
//  Flags and word_count hold through DONE/IDLE; only start or rst_n clears them.
//  rst_n low mid-LOAD aborts immediately: pending write is discarded, imem_we=0, all outputs at reset values.
// TESTING
//  start, then ADDI rd=1 rs1=0 f3=0 imm=5, last, imem_ready=1
//   -> one write addr=0 data=32'h0050_0093; done pulse; word_count=1.
//  R sub rd=3 rs1=1 rs2=2 f7b5=1 f3=0, then BEQ rs1=1 rs2=2 imm=-8 last
//   -> 32'h4020_81B3 @0, 32'hFE20_8CE3 @4.
//  SW rs1=2 rs2=5 imm=12; JAL rd=1 imm=2048; LW rd=4 rs1=2 imm=-4
//   -> 32'h0051_2623, 32'h0010_00EF, 32'hFFC1_2203 at addrs 0, 4, 8.
//  Hold imem_ready=0 for 3 cycles with a second bundle offered
//   -> imem_wdata/addr stable; in_ready=0; second word issued the cycle after handshake.
//  ADDI imm=2048; BEQ imm=3; class=7
//   -> err_imm=1, err_illegal=1; zero writes; word_count=0.
//  MAX_WORDS=2 with 3 bundles -> 2 writes, err_ovf=1, done pulse.
//   Then assert rst_n=0 mid-LOAD of a new run -> imem_we=0 and flags=0 immediately.

Source files
------------

// File: rtl/instr_encoder_loader_if.sv
// instr_encoder_loader_if: field-bundle input channel and imem write channel of the instruction loader
interface instr_encoder_loader_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_class;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [2:0]  in_funct3;
  logic        in_funct7b5;
  logic [20:0] in_imm;
  logic        in_last;
  logic        imem_we;
  logic        imem_ready;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  modport master (
    output in_valid, in_class, in_rd, in_rs1, in_rs2, in_funct3, in_funct7b5, in_imm, in_last, imem_ready,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );
  modport slave (
    input  in_valid, in_class, in_rd, in_rs1, in_rs2, in_funct3, in_funct7b5, in_imm, in_last, imem_ready,
    output in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: packs RV32I field bundles into instruction words and streams them into imem
module instr_encoder_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 256
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  instr_encoder_loader_if.slave        bus,
  output logic                         busy,
  output logic                         done,
  output logic [8:0]                   word_count,
  output logic                         err_illegal,
  output logic                         err_imm,
  output logic                         err_ovf
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0]  state;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] enc;
  logic [20:0] imm;
  logic [2:0]  cls;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  f3;
  logic        we;
  logic        last_seen;
  logic        rdy;
  logic        acc;
  logic        good;
  logic        bad;
  logic        ill;
  logic        ovf;
  logic        fit12;
  logic        fit13;
  logic        full;
  logic        hs;
  logic        finish;
  assign imm = bus.in_imm;
  assign cls = bus.in_class;
  assign rd  = bus.in_rd;
  assign rs1 = bus.in_rs1;
  assign rs2 = bus.in_rs2;
  assign f3  = bus.in_funct3;
  always_comb begin
    fit12  = imm[20:11] == {10{imm[11]}};
    fit13  = imm[20:12] == {9{imm[12]}};
    ill    = cls > 3'd5;
    bad    = (cls == 3'd1 || cls == 3'd2 || cls == 3'd4) ? !fit12 :
             cls == 3'd3 ? (!fit13 || imm[0]) : (cls == 3'd5 && imm[0]);
    enc    = cls == 3'd0 ? {1'b0, bus.in_funct7b5, 5'b0, rs2, rs1, f3, rd, 7'b0110011} :
             cls == 3'd1 ? {imm[11:0], rs1, 3'b010, rd, 7'b0000011} :
             cls == 3'd2 ? {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011} :
             cls == 3'd3 ? {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011} :
             cls == 3'd4 ? {imm[11:0], rs1, f3, rd, 7'b0010011} :
                           {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    hs     = we && bus.imem_ready;
    full   = {1'b0, word_count} + {9'd0, we} >= 10'(MAX_WORDS);
    rdy    = state == LOAD && (!we || bus.imem_ready) && !last_seen && !full;
    acc    = bus.in_valid && rdy;
    good   = acc && !ill && !bad;
    ovf    = state == LOAD && bus.in_valid && !we && !last_seen && word_count == 9'(MAX_WORDS);
    finish = ovf || (state == LOAD && last_seen && (!we || bus.imem_ready));
  end
  assign bus.in_ready   = rdy;
  assign bus.imem_we    = we;
  assign bus.imem_addr  = addr;
  assign bus.imem_wdata = wdata;
  assign busy           = state != IDLE;
  assign done           = state == DONE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      we          <= 1'b0;
      addr        <= BASE_ADDR;
      wdata       <= '0;
      word_count  <= '0;
      last_seen   <= 1'b0;
      err_illegal <= 1'b0;
      err_imm     <= 1'b0;
      err_ovf     <= 1'b0;
    end else if (state == IDLE) begin
      if (start) begin
        state       <= LOAD;
        addr        <= BASE_ADDR;
        word_count  <= '0;
        last_seen   <= 1'b0;
        err_illegal <= 1'b0;
        err_imm     <= 1'b0;
        err_ovf     <= 1'b0;
      end
    end else if (state == DONE) begin
      state <= IDLE;
    end else begin
      we <= good || (we && !bus.imem_ready);
      if (good) wdata <= enc;
      if (hs) addr <= addr + 32'd4;
      if (hs) word_count <= word_count + {8'd0, word_count != 9'(MAX_WORDS)};
      if (acc && bus.in_last) last_seen <= 1'b1;
      if (acc && ill) err_illegal <= 1'b1;
      if (acc && bad) err_imm <= 1'b1;
      if (ovf) err_ovf <= 1'b1;
      if (finish) state <= DONE;
    end
  end
endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb_instr_encoder_loader: randomized scoreboard bench for the instruction encoder/loader
module tb_instr_encoder_loader;
  typedef struct packed {
    logic [2:0]  cls;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic        f7;
    logic [20:0] imm;
    logic        last;
  } bund_t;
  localparam logic [31:0] BASE2 = 32'h0000_1000;
  logic clk = 0, rst_n = 0, start = 0, sel = 0, in_valid = 0, ready_val = 0, rnd_ready = 0;
  bund_t cur = '0;
  logic busy1, done1, ill1, imm1, ovf1, busy2, done2, ill2, imm2, ovf2;
  logic [8:0] cnt1, cnt2;
  int total = 0, bad = 0, done_cnt = 0, base_done = 0, exp_cnt = 0, max_words = 256;
  logic [31:0] exp_addr = 0;
  bit exp_ill, exp_imm, exp_ovf;
  logic [63:0] sb[$];
  instr_encoder_loader_if b1();
  instr_encoder_loader_if b2();
  always #5 clk = ~clk;
  assign b1.in_valid = in_valid && !sel;
  assign b2.in_valid = in_valid && sel;
  assign {b1.in_class, b1.in_rd, b1.in_rs1, b1.in_rs2, b1.in_funct3, b1.in_funct7b5, b1.in_imm, b1.in_last} = cur;
  assign {b2.in_class, b2.in_rd, b2.in_rs1, b2.in_rs2, b2.in_funct3, b2.in_funct7b5, b2.in_imm, b2.in_last} = cur;
  assign b1.imem_ready = ready_val;
  assign b2.imem_ready = ready_val;
  instr_encoder_loader dut1 (.clk(clk), .rst_n(rst_n), .start(start && !sel), .bus(b1), .busy(busy1), .done(done1),
    .word_count(cnt1), .err_illegal(ill1), .err_imm(imm1), .err_ovf(ovf1));
  instr_encoder_loader #(.BASE_ADDR(BASE2), .MAX_WORDS(2)) dut2 (.clk(clk), .rst_n(rst_n), .start(start && sel),
    .bus(b2), .busy(busy2), .done(done2), .word_count(cnt2), .err_illegal(ill2), .err_imm(imm2), .err_ovf(ovf2));
  logic a_we, d_in_ready, d_busy, d_done, d_ill, d_imm, d_ovf;
  logic [31:0] a_addr, a_wdata;
  logic [8:0] d_cnt;
  assign a_we       = sel ? b2.imem_we : b1.imem_we;
  assign a_addr     = sel ? b2.imem_addr : b1.imem_addr;
  assign a_wdata    = sel ? b2.imem_wdata : b1.imem_wdata;
  assign d_in_ready = sel ? b2.in_ready : b1.in_ready;
  assign d_busy     = sel ? busy2 : busy1;
  assign d_done     = sel ? done2 : done1;
  assign d_cnt      = sel ? cnt2 : cnt1;
  assign d_ill      = sel ? ill2 : ill1;
  assign d_imm      = sel ? imm2 : imm1;
  assign d_ovf      = sel ? ovf2 : ovf1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic bund_t mk(input int c, input int d, input int s1, input int s2, input int f3, input int f7,
                               input int imm, input int last);
    return {3'(c), 5'(d), 5'(s1), 5'(s2), 3'(f3), 1'(f7), 21'(imm), 1'(last)};
  endfunction
  function automatic int verdict(input bund_t b);
    int v = 32'($signed(b.imm));
    if (b.cls > 3'd5) return 1;
    if (b.cls == 3'd1 || b.cls == 3'd2 || b.cls == 3'd4) return (v < -2048 || v > 2047) ? 2 : 0;
    if (b.cls == 3'd3) return (v < -4096 || v > 4094 || v % 2 != 0) ? 2 : 0;
    return v % 2 != 0 ? 2 : 0;
  endfunction
  function automatic logic [31:0] enc_model(input bund_t b);
    logic [31:0] u = 32'($signed(b.imm));
    logic [31:0] rd = 32'(b.rd) << 7;
    logic [31:0] r1 = 32'(b.rs1) << 15;
    logic [31:0] r2 = 32'(b.rs2) << 20;
    case (b.cls)
      3'd0: return 32'h33 | rd | 32'(b.f3) << 12 | r1 | r2 | 32'(b.f7) << 30;
      3'd1: return 32'h03 | rd | 32'h2000 | r1 | (u & 32'hfff) << 20;
      3'd2: return 32'h23 | (u & 32'h1f) << 7 | 32'h2000 | r1 | r2 | ((u >> 5) & 32'h7f) << 25;
      3'd3: return 32'h63 | ((u >> 11) & 32'h1) << 7 | ((u >> 1) & 32'hf) << 8 | r1 | r2 |
                   ((u >> 5) & 32'h3f) << 25 | ((u >> 12) & 32'h1) << 31;
      3'd4: return 32'h13 | rd | 32'(b.f3) << 12 | r1 | (u & 32'hfff) << 20;
      default: return 32'h6f | rd | ((u >> 12) & 32'hff) << 12 | ((u >> 11) & 32'h1) << 20 |
                      ((u >> 1) & 32'h3ff) << 21 | ((u >> 20) & 32'h1) << 31;
    endcase
  endfunction
  function automatic bund_t rand_bund(input bit last);
    bund_t b;
    int r = $urandom_range(0, 9);
    b.cls = r < 8 ? 3'($urandom_range(0, 5)) : 3'($urandom_range(6, 7));
    b.rd  = 5'($urandom);
    b.rs1 = 5'($urandom);
    b.rs2 = 5'($urandom);
    b.f3  = 3'($urandom);
    b.f7  = 1'($urandom);
    r = $urandom_range(0, 5);
    b.imm = r == 0 ? 21'($urandom) : r == 1 ? 21'($signed(13'($urandom))) : 21'($signed(12'($urandom)));
    if ($urandom_range(0, 4) != 0) b.imm[0] = 1'b0;
    b.last = last;
    return b;
  endfunction
  task automatic send(input bund_t b, input logic [32:0] lit);
    int n = 0;
    int v;
    bit taken = 0;
    bit gone = 0;
    cur = b;
    in_valid = 1;
    while (!taken && !gone && n < 100) begin
      @(negedge clk);
      if (d_in_ready) begin
        taken = 1;
        v = verdict(b);
        if (v == 1) exp_ill = 1;
        else if (v == 2) exp_imm = 1;
        else begin
          sb.push_back({exp_addr, lit[32] ? lit[31:0] : enc_model(b)});
          exp_addr += 4;
          exp_cnt++;
        end
      end else if (!d_busy) gone = 1;
      else n++;
      @(posedge clk);
      #1;
    end
    in_valid = 0;
    if (!taken) begin
      chk("bundle refused only when full", 32'(exp_cnt == max_words), 1);
      if (exp_cnt == max_words) exp_ovf = 1;
    end
  endtask
  task automatic do_start(input bit s);
    sel = s;
    max_words = s ? 2 : 256;
    exp_addr = s ? BASE2 : 32'h0;
    exp_cnt = 0;
    exp_ill = 0;
    exp_imm = 0;
    exp_ovf = 0;
    sb.delete();
    base_done = done_cnt;
    start = 1;
    @(posedge clk);
    #1;
    start = 0;
  endtask
  task automatic finish_run(input string name);
    int n = 0;
    while (d_busy && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk({name, " completes"}, 32'(n < 500), 1);
    @(posedge clk);
    #1;
    chk({name, " word_count"}, 32'(d_cnt), 32'(exp_cnt));
    chk({name, " err_illegal"}, 32'(d_ill), 32'(exp_ill));
    chk({name, " err_imm"}, 32'(d_imm), 32'(exp_imm));
    chk({name, " err_ovf"}, 32'(d_ovf), 32'(exp_ovf));
    chk({name, " done pulses"}, done_cnt - base_done, 1);
    chk({name, " writes pending"}, sb.size(), 0);
  endtask
  initial forever begin
    @(posedge clk);
    #1;
    if (rnd_ready) ready_val = 1'($urandom);
  end
  initial forever begin
    logic [63:0] e;
    @(negedge clk);
    if (d_done) done_cnt++;
    if (a_we && ready_val) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL write: unexpected word %h at %h", a_wdata, a_addr);
      end else begin
        e = sb.pop_front();
        chk("wdata", a_wdata, e[31:0]);
        chk("waddr", a_addr, e[63:32]);
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst imem_we", 32'(a_we), 0);
    chk("rst imem_addr", a_addr, 0);
    chk("rst imem_wdata", a_wdata, 0);
    chk("rst in_ready", 32'(d_in_ready), 0);
    chk("rst busy", 32'(d_busy), 0);
    chk("rst done", 32'(d_done), 0);
    chk("rst word_count", 32'(d_cnt), 0);
    chk("rst flags", 32'({d_ill, d_imm, d_ovf}), 0);
    chk("rst addr base2", b2.imem_addr, BASE2);
    rst_n = 1;
    @(posedge clk);
    #1;
    ready_val = 1;
    do_start(0);
    chk("busy after start", 32'(d_busy), 1);
    send(mk(4, 1, 0, 0, 0, 0, 5, 1), {1'b1, 32'h0050_0093});
    finish_run("addi");
    do_start(0);
    send(mk(0, 3, 1, 2, 0, 1, 0, 0), {1'b1, 32'h4020_81B3});
    send(mk(3, 0, 1, 2, 0, 0, -8, 1), {1'b1, 32'hFE20_8CE3});
    finish_run("sub_beq");
    do_start(0);
    send(mk(2, 0, 2, 5, 0, 0, 12, 0), {1'b1, 32'h0051_2623});
    send(mk(5, 1, 0, 0, 0, 0, 2048, 0), {1'b1, 32'h0010_00EF});
    send(mk(1, 4, 2, 0, 0, 0, -4, 1), {1'b1, 32'hFFC1_2203});
    finish_run("sw_jal_lw");
    do_start(0);
    ready_val = 0;
    send(mk(4, 5, 0, 0, 0, 0, 1, 0), {1'b1, 32'h0010_0293});
    cur = mk(4, 6, 0, 0, 0, 0, 2, 1);
    in_valid = 1;
    sb.push_back({32'h4, 32'h0020_0313});
    exp_cnt = 2;
    repeat (3) begin
      @(negedge clk);
      chk("stall in_ready", 32'(d_in_ready), 0);
      chk("stall imem_we", 32'(a_we), 1);
      chk("stall wdata", a_wdata, 32'h0010_0293);
      chk("stall addr", a_addr, 0);
    end
    @(posedge clk);
    #1;
    ready_val = 1;
    @(negedge clk);
    chk("release in_ready", 32'(d_in_ready), 1);
    @(posedge clk);
    #1;
    in_valid = 0;
    @(negedge clk);
    chk("next imem_we", 32'(a_we), 1);
    chk("next wdata", a_wdata, 32'h0020_0313);
    chk("next addr", a_addr, 4);
    @(posedge clk);
    #1;
    finish_run("stall");
    do_start(0);
    send(mk(4, 1, 0, 0, 0, 0, 2048, 0), 33'd0);
    send(mk(3, 0, 1, 2, 0, 0, 3, 0), 33'd0);
    send(mk(7, 1, 1, 1, 0, 0, 0, 1), 33'd0);
    finish_run("rejects");
    for (int p = 0; p < 8; p++) begin
      int len = $urandom_range(1, 24);
      rnd_ready = p % 3 != 0;
      ready_val = 1;
      do_start(0);
      for (int i = 0; i < len; i++) send(rand_bund(i == len - 1), 33'd0);
      finish_run("random");
    end
    rnd_ready = 0;
    ready_val = 1;
    do_start(1);
    for (int i = 0; i < 3; i++) send(mk(4, i + 1, 0, 0, 0, 0, i, 0), 33'd0);
    finish_run("overflow");
    do_start(1);
    chk("start clears ovf", 32'(d_ovf), 0);
    send(mk(6, 1, 1, 1, 0, 0, 0, 0), 33'd0);
    ready_val = 0;
    send(mk(4, 7, 0, 0, 0, 0, 9, 0), 33'd0);
    chk("pre-abort imem_we", 32'(a_we), 1);
    chk("pre-abort err_illegal", 32'(d_ill), 1);
    rst_n = 0;
    #1;
    sb.delete();
    chk("abort imem_we", 32'(a_we), 0);
    chk("abort busy", 32'(d_busy), 0);
    chk("abort flags", 32'({d_ill, d_imm, d_ovf}), 0);
    chk("abort word_count", 32'(d_cnt), 0);
    chk("abort addr", a_addr, BASE2);
    chk("abort done", 32'(d_done), 0);
    @(posedge clk);
    #1;
    rst_n = 1;
    ready_val = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle after abort", 32'(d_busy), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
